// File: rtl/mpsub256_serial.sv
// Serial 256-bit subtractor: one LIMB_W-bit limb per clock, least significant limb first,
// producing a 257-bit two's-complement difference with the final borrow in bit 256.
module mpsub256_serial #(
   parameter int LIMB_W = 32
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic [255:0] a_in,
   input  logic [255:0] b_in,
   input  logic         write,
   input  logic         start,
   output logic [256:0] d_out,
   output logic         ready,
   output logic         busy
);

   localparam int N_LIMBS = 256 / LIMB_W;
   localparam int IDX_W   = $clog2(N_LIMBS);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [IDX_W-1:0]   idx;
   logic               borrow;
   logic [255:0]       a_reg;
   logic [255:0]       b_reg;

   logic               load_op;
   logic               step;
   logic               first;
   logic               last;
   logic [7:0]         limb_base;
   logic [LIMB_W-1:0]  a_limb;
   logic [LIMB_W-1:0]  b_limb;
   logic               borrow_in;
   logic [LIMB_W:0]    diff_ext;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Start wins over write in IDLE; both are ignored while a run is in flight.
   always_comb begin
      state_next = state;
      load_op    = 1'b0;
      step       = 1'b0;
      first      = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               step       = 1'b1;
               first      = 1'b1;
               state_next = RUN;
            end else if (write) begin
               load_op = 1'b1;
            end
         end
         RUN: begin
            step = 1'b1;
            if (idx == IDX_W'(N_LIMBS - 1)) begin
               last       = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // idx is always 0 in IDLE, so limb 0 is selected on the launching edge.
   always_comb begin
      limb_base = 8'(idx) * 8'(LIMB_W);
      a_limb    = a_reg[limb_base +: LIMB_W];
      b_limb    = b_reg[limb_base +: LIMB_W];
      borrow_in = first ? 1'b0 : borrow;
      diff_ext  = {1'b0, a_limb} - {1'b0, b_limb} - {{LIMB_W{1'b0}}, borrow_in};
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         idx    <= '0;
         borrow <= 1'b0;
         ready  <= 1'b0;
         d_out  <= '0;
         a_reg  <= '0;
         b_reg  <= '0;
      end else begin
         ready <= last;
         if (load_op) begin
            a_reg <= a_in;
            b_reg <= b_in;
         end
         if (step) begin
            d_out[limb_base +: LIMB_W] <= diff_ext[LIMB_W-1:0];
            borrow                     <= diff_ext[LIMB_W];
            idx                        <= last ? '0 : idx + 1'b1;
            if (last) begin
               d_out[256] <= diff_ext[LIMB_W];
            end
         end
      end
   end

   assign busy = (state == RUN);

endmodule

// File: tb/tb_mpsub256_serial.sv
// Bench for mpsub256_serial: table vectors, hand-built corner sequences and LFSR operands,
// with expected differences queued at launch and compared when ready pulses.
module tb_mpsub256_serial;

   logic         CLK = 1'b0;
   logic         RST;
   logic [255:0] a_in;
   logic [255:0] b_in;
   logic         write32, start32, write64, start64;
   logic [256:0] d32, d64;
   logic         ready32, ready64, busy32, busy64;

   always #5 CLK = ~CLK;

   mpsub256_serial #(.LIMB_W(32)) dut32 (
      .CLK(CLK), .RST(RST), .a_in(a_in), .b_in(b_in), .write(write32), .start(start32),
      .d_out(d32), .ready(ready32), .busy(busy32)
   );

   mpsub256_serial #(.LIMB_W(64)) dut64 (
      .CLK(CLK), .RST(RST), .a_in(a_in), .b_in(b_in), .write(write64), .start(start64),
      .d_out(d64), .ready(ready64), .busy(busy64)
   );

   typedef struct {
      logic [255:0] a;
      logic [255:0] b;
      logic [256:0] d;
   } vec_t;

   vec_t         vecs[7];
   logic [256:0] exp_q[$];
   int           checks = 0;
   int           errors = 0;
   bit           use64 = 1'b0;
   logic [63:0]  lfsr = 64'h1234_5678_9ABC_DEF1;

   function automatic logic [256:0] golden(input logic [255:0] a, input logic [255:0] b);
      return {1'b0, a} - {1'b0, b};
   endfunction

   function automatic logic cur_ready();
      return use64 ? ready64 : ready32;
   endfunction

   function automatic logic cur_busy();
      return use64 ? busy64 : busy32;
   endfunction

   function automatic logic [256:0] cur_d();
      return use64 ? d64 : d32;
   endfunction

   function automatic int n_limbs();
      return use64 ? 4 : 8;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input logic [256:0] act, input logic [256:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_write(input logic v);
      if (use64) write64 = v; else write32 = v;
   endtask

   task automatic set_start(input logic v);
      if (use64) start64 = v; else start32 = v;
   endtask

   task automatic loadOperands(input logic [255:0] a, input logic [255:0] b);
      a_in = a;
      b_in = b;
      set_write(1'b1);
      tick();
      set_write(1'b0);
   endtask

   task automatic launch(input logic [256:0] exp);
      set_start(1'b1);
      exp_q.push_back(exp);
      tick();
      set_start(1'b0);
   endtask

   task automatic applyStimulus(input logic [255:0] a, input logic [255:0] b, input logic [256:0] exp);
      loadOperands(a, b);
      launch(exp);
   endtask

   // Waits for ready, then checks latency, busy, result, the pulse width and the hold.
   task automatic checkOutput(input string name, input int exp_cycles);
      int           cycles;
      bit           busy_ok;
      logic [256:0] exp;
      cycles  = 0;
      busy_ok = 1'b1;
      do begin
         tick();
         cycles++;
         if (!cur_ready() && !cur_busy()) busy_ok = 1'b0;
      end while (!cur_ready() && cycles < 200);
      if (!cur_ready()) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s timeout: ready=%0b after %0d cycles, required ready=1", name, cur_ready(), cycles);
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         return;
      end
      exp = exp_q.pop_front();
      check({name, " latency"}, 257'(cycles), 257'(exp_cycles));
      check({name, " busy during run"}, 257'(busy_ok), 257'(1));
      check({name, " busy at ready"}, 257'(cur_busy()), 257'(0));
      check({name, " d_out"}, cur_d(), exp);
      tick();
      check({name, " ready drop"}, 257'(cur_ready()), 257'(0));
      check({name, " d_out hold"}, cur_d(), exp);
   endtask

   task automatic rand256(output logic [255:0] v);
      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < 17; j++) begin
            lfsr = lfsr[0] ? ((lfsr >> 1) ^ 64'hD800_0000_0000_0000) : (lfsr >> 1);
         end
         v[k*64 +: 64] = lfsr;
      end
   endtask

   initial begin
      #3ms;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [255:0] ra, rb;
      logic         saw;

      vecs[0] = '{a: 256'd5,       b: 256'd3,       d: 257'h2};
      vecs[1] = '{a: 256'd0,       b: 256'd1,       d: {257{1'b1}}};
      vecs[2] = '{a: 256'h1_0000_0000, b: 256'd1,   d: 257'hFFFF_FFFF};
      vecs[3] = '{a: {256{1'b1}},  b: 256'd0,       d: {1'b0, {256{1'b1}}}};
      vecs[4] = '{a: {128{2'b10}}, b: {128{2'b10}}, d: 257'd0};
      vecs[5] = '{a: 256'd0,       b: {256{1'b1}},  d: {1'b1, 255'd0, 1'b1}};
      vecs[6] = '{a: {1'b1, 255'd0}, b: 256'd1,     d: {2'b00, {255{1'b1}}}};

      // Reset overrides simultaneous write and start.
      RST = 1'b1;
      a_in = {8{32'hDEAD_BEEF}};
      b_in = 256'd1;
      write32 = 1'b1; start32 = 1'b1; write64 = 1'b1; start64 = 1'b1;
      tick();
      tick();
      check("reset d_out", d32, 257'd0);
      check("reset busy", 257'(busy32), 257'(0));
      check("reset ready", 257'(ready32), 257'(0));
      check("reset busy64", 257'(busy64), 257'(0));
      RST = 1'b0;
      write32 = 1'b0; start32 = 1'b0; write64 = 1'b0; start64 = 1'b0;
      tick();
      launch(257'd0);
      checkOutput("post-reset operands zero", 7);

      for (int w = 0; w < 2; w++) begin
         use64 = (w == 1);
         for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].d);
            checkOutput($sformatf("vec%0d w%0d", i, w), n_limbs() - 1);
         end
      end
      use64 = 1'b0;

      // Reset three edges into a run aborts it and clears the operands.
      applyStimulus(256'd5, 256'd3, 257'd2);
      tick();
      tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      exp_q.delete();
      check("abort d_out", d32, 257'd0);
      check("abort busy", 257'(busy32), 257'(0));
      saw = 1'b0;
      repeat (12) begin
         if (ready32) saw = 1'b1;
         tick();
      end
      check("abort no ready", 257'(saw), 257'(0));
      applyStimulus(256'd10, 256'd4, 257'd6);
      checkOutput("after abort", 7);

      // Writes and starts during a run, then write+start together, must not disturb operands.
      loadOperands(256'd100, 256'd58);
      launch(257'd42);
      tick();
      a_in = 256'd999;
      b_in = 256'd1;
      write32 = 1'b1;
      start32 = 1'b1;
      tick();
      tick();
      write32 = 1'b0;
      start32 = 1'b0;
      checkOutput("ignore in run", 4);
      a_in = 256'd777;
      b_in = 256'd7;
      write32 = 1'b1;
      launch(257'd42);
      write32 = 1'b0;
      checkOutput("start over write", 7);
      launch(257'd42);
      checkOutput("write dropped", 7);

      // Start held high gives back-to-back runs.
      loadOperands(256'd0, 256'd2);
      start32 = 1'b1;
      exp_q.push_back({257{1'b1}} - 257'd1);
      exp_q.push_back({257{1'b1}} - 257'd1);
      exp_q.push_back({257{1'b1}} - 257'd1);
      tick();
      checkOutput("b2b run1", 7);
      checkOutput("b2b run2", 7);
      start32 = 1'b0;
      checkOutput("b2b run3", 7);
      saw = 1'b0;
      repeat (10) begin
         if (ready32 || busy32) saw = 1'b1;
         tick();
      end
      check("b2b stops", 257'(saw), 257'(0));

      for (int w = 0; w < 2; w++) begin
         use64 = (w == 1);
         for (int i = 0; i < 1000; i++) begin
            rand256(ra);
            rand256(rb);
            if (i % 5 == 0) rb = ra;
            if (i % 7 == 0) rb = {ra[255:32], ra[31:0] + 32'd1};
            applyStimulus(ra, rb, golden(ra, rb));
            checkOutput($sformatf("rand%0d w%0d", i, w), n_limbs() - 1);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
